// File: rtl/chords_player.sv
// ---------------------------------------------------------------------------
// chords_player
//
// Three-voice triangle-wave chord synthesiser.
// - Each voice holds a note, a beat countdown and a 20-bit phase accumulator.
// - Voices are allocated on new_note, count down on beat, and are released
//   on the first new_frame after their countdown expires.
// - A sample request advances all phases.
// - One cycle later, the mixed sample is presented with a one-cycle ready
//   strobe.
//
// Ports
//   clk                  : system clock, rising edge
//   reset                : asynchronous reset, active low
//   new_frame            : frame-boundary strobe, releases finished voices
//   play                 : 1 = run, 0 = pause (phases and countdown frozen)
//   note[5:0]            : note code, 1 = A1 (55 Hz) in semitone steps, 0 = rest
//   duration[5:0]        : note length in beats
//   new_note             : strobe qualifying note/duration
//   beat                 : beat strobe
//   generate_next_sample : sample request strobe
//   sample_out[15:0]     : signed mixed sample
//   new_sample_ready     : one-cycle strobe, sample_out valid
//
// Optional build macro
//   CHORDS_PLAYER_VOICE_STEAL_EN : when defined, a new note arriving with all
//   voices busy replaces the voice with the fewest remaining beats (lowest
//   index on tie). When undefined, such a note is dropped.
// ---------------------------------------------------------------------------
module chords_player (
    input  logic               clk,
    input  logic               reset,
    input  logic               new_frame,
    input  logic               play,
    input  logic [5:0]         note,
    input  logic [5:0]         duration,
    input  logic               new_note,
    input  logic               beat,
    input  logic               generate_next_sample,
    output logic signed [15:0] sample_out,
    output logic               new_sample_ready
);

    localparam int NUM_VOICES = 3;

    logic [NUM_VOICES-1:0] voice_busy;
    logic [NUM_VOICES-1:0] voice_done;
    logic [5:0]            voice_note      [NUM_VOICES];
    logic [5:0]            voice_remaining [NUM_VOICES];
    logic [19:0]           voice_phase     [NUM_VOICES];

    logic                  req_pending;
    logic                  req_play;

    logic                  load_en;
    logic [1:0]            load_idx;
    logic signed [15:0]    mix;
    logic [12:0]           tri_val;
    logic signed [15:0]    voice_val;

    // Phase increment per sample at 48 kHz: round(2^20 * f(n) / 48000)
    function automatic logic [19:0] phase_step(input logic [5:0] n);
        case (n)
            6'd1:  phase_step = 20'd1201;   6'd2:  phase_step = 20'd1273;
            6'd3:  phase_step = 20'd1349;   6'd4:  phase_step = 20'd1429;
            6'd5:  phase_step = 20'd1514;   6'd6:  phase_step = 20'd1604;
            6'd7:  phase_step = 20'd1699;   6'd8:  phase_step = 20'd1800;
            6'd9:  phase_step = 20'd1907;   6'd10: phase_step = 20'd2021;
            6'd11: phase_step = 20'd2141;   6'd12: phase_step = 20'd2268;
            6'd13: phase_step = 20'd2403;   6'd14: phase_step = 20'd2546;
            6'd15: phase_step = 20'd2697;   6'd16: phase_step = 20'd2858;
            6'd17: phase_step = 20'd3028;   6'd18: phase_step = 20'd3208;
            6'd19: phase_step = 20'd3398;   6'd20: phase_step = 20'd3600;
            6'd21: phase_step = 20'd3815;   6'd22: phase_step = 20'd4041;
            6'd23: phase_step = 20'd4282;   6'd24: phase_step = 20'd4536;
            6'd25: phase_step = 20'd4806;   6'd26: phase_step = 20'd5092;
            6'd27: phase_step = 20'd5395;   6'd28: phase_step = 20'd5715;
            6'd29: phase_step = 20'd6055;   6'd30: phase_step = 20'd6415;
            6'd31: phase_step = 20'd6797;   6'd32: phase_step = 20'd7201;
            6'd33: phase_step = 20'd7629;   6'd34: phase_step = 20'd8083;
            6'd35: phase_step = 20'd8563;   6'd36: phase_step = 20'd9072;
            6'd37: phase_step = 20'd9612;   6'd38: phase_step = 20'd10184;
            6'd39: phase_step = 20'd10789;  6'd40: phase_step = 20'd11431;
            6'd41: phase_step = 20'd12110;  6'd42: phase_step = 20'd12830;
            6'd43: phase_step = 20'd13593;  6'd44: phase_step = 20'd14402;
            6'd45: phase_step = 20'd15258;  6'd46: phase_step = 20'd16165;
            6'd47: phase_step = 20'd17127;  6'd48: phase_step = 20'd18145;
            6'd49: phase_step = 20'd19224;  6'd50: phase_step = 20'd20367;
            6'd51: phase_step = 20'd21578;  6'd52: phase_step = 20'd22861;
            6'd53: phase_step = 20'd24221;  6'd54: phase_step = 20'd25661;
            6'd55: phase_step = 20'd27187;  6'd56: phase_step = 20'd28803;
            6'd57: phase_step = 20'd30516;  6'd58: phase_step = 20'd32331;
            6'd59: phase_step = 20'd34253;  6'd60: phase_step = 20'd36290;
            6'd61: phase_step = 20'd38448;  6'd62: phase_step = 20'd40734;
            6'd63: phase_step = 20'd43156;
            default: phase_step = 20'd0;
        endcase
    endfunction

    // Voice allocation: the lowest-index free voice takes the new note.
    // Busy flags are registered, so back-to-back strobes see the previous
    // load and fill consecutive voices.
`ifdef CHORDS_PLAYER_VOICE_STEAL_EN
    logic [5:0] min_rem;
`endif
    always_comb begin
        load_en  = 1'b0;
        load_idx = 2'd0;
`ifdef CHORDS_PLAYER_VOICE_STEAL_EN
        min_rem  = voice_remaining[0];
`endif
        if (new_note && (note != 6'd0) && (duration != 6'd0)) begin
            for (int i = NUM_VOICES - 1; i >= 0; i--) begin
                if (!voice_busy[i]) begin
                    load_en  = 1'b1;
                    load_idx = 2'(i);
                end
            end
`ifdef CHORDS_PLAYER_VOICE_STEAL_EN
            // All voices busy: steal the one closest to finishing; a strict
            // less-than keeps the lowest index on ties.
            if (&voice_busy) begin
                load_en = 1'b1;
                for (int i = 1; i < NUM_VOICES; i++) begin
                    if (voice_remaining[i] < min_rem) begin
                        min_rem  = voice_remaining[i];
                        load_idx = 2'(i);
                    end
                end
            end
`endif
        end
    end

    // Triangle mix of all busy voices; each voice is centred around zero.
    always_comb begin
        mix       = 16'sd0;
        tri_val   = 13'd0;
        voice_val = 16'sd0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (voice_busy[i]) begin
                tri_val   = voice_phase[i][19] ? ~voice_phase[i][18:6] : voice_phase[i][18:6];
                voice_val = $signed({2'b00, tri_val, 1'b0}) - 16'sd8192;
                mix       = mix + voice_val;
            end
        end
    end

    // Voice state: a load wins over release and countdown; a release uses the
    // registered done flag, so a voice finishing on a frame edge lingers until
    // the next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            voice_busy <= '0;
            voice_done <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                voice_note[i]      <= 6'd0;
                voice_remaining[i] <= 6'd0;
                voice_phase[i]     <= 20'd0;
            end
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (load_en && (load_idx == 2'(i))) begin
                    voice_busy[i]      <= 1'b1;
                    voice_done[i]      <= 1'b0;
                    voice_note[i]      <= note;
                    voice_remaining[i] <= duration;
                    voice_phase[i]     <= 20'd0;
                end else if (new_frame && voice_done[i]) begin
                    voice_busy[i]      <= 1'b0;
                    voice_done[i]      <= 1'b0;
                    voice_note[i]      <= 6'd0;
                    voice_remaining[i] <= 6'd0;
                    voice_phase[i]     <= 20'd0;
                end else if (voice_busy[i]) begin
                    if (beat && play && !voice_done[i]) begin
                        voice_remaining[i] <= voice_remaining[i] - 6'd1;
                        if (voice_remaining[i] == 6'd1) begin
                            voice_done[i] <= 1'b1;
                        end
                    end
                    if (generate_next_sample && play) begin
                        voice_phase[i] <= voice_phase[i] + phase_step(voice_note[i]);
                    end
                end
            end
        end
    end

    // Output stage: a request advances phases on one edge and the mix of the
    // advanced phases is registered on the next; play is captured with the
    // request so a paused request yields silence.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_pending      <= 1'b0;
            req_play         <= 1'b0;
            sample_out       <= 16'sd0;
            new_sample_ready <= 1'b0;
        end else begin
            req_pending      <= generate_next_sample;
            req_play         <= play;
            new_sample_ready <= req_pending;
            if (req_pending) begin
                sample_out <= req_play ? mix : 16'sd0;
            end
        end
    end

endmodule

// File: tb/tb_chords_player.sv
// ---------------------------------------------------------------------------
// tb_chords_player
//
// Scoreboard bench for chords_player. A reference model of the three voices
// runs on every clock edge and queues the sample it expects for each request.
// A separate monitor pops that queue and compares on every ready strobe.
// Directed chord scenarios are followed by a randomized phase and a
// mid-request reset.
// ---------------------------------------------------------------------------
module tb_chords_player;

    logic               clk;
    logic               reset;
    logic               new_frame;
    logic               play;
    logic [5:0]         note;
    logic [5:0]         duration;
    logic               new_note;
    logic               beat;
    logic               generate_next_sample;
    logic signed [15:0] sample_out;
    logic               new_sample_ready;

    int errors = 0;
    int checks = 0;

    chords_player dut (
        .clk                  (clk),
        .reset                (reset),
        .new_frame            (new_frame),
        .play                 (play),
        .note                 (note),
        .duration             (duration),
        .new_note             (new_note),
        .beat                 (beat),
        .generate_next_sample (generate_next_sample),
        .sample_out           (sample_out),
        .new_sample_ready     (new_sample_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, one entry per voice
    int m_busy [3];
    int m_done [3];
    int m_note [3];
    int m_rem  [3];
    int m_phase[3];
    bit m_pend;
    bit m_pend_play;
    int exp_q[$];

    // Phase increment derived from the musical frequency of the note
    function automatic int step_of(input int n);
        real r;
        r = (2.0 ** 20) * 55.0 * (2.0 ** ((n - 1) / 12.0)) / 48000.0;
        return int'($floor(r + 0.5));
    endfunction

    // Triangle: rises over the first half of the cycle, falls over the second
    function automatic int voice_value(input int ph);
        int t;
        t = (ph / 64) % 8192;
        if (ph >= 524288) t = 8191 - t;
        return 2 * t - 8192;
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: at each edge, answer the pending request from the state reached
    // after the previous edge, then apply this edge's strobes.
    always @(posedge clk or negedge reset) begin : model
        int tgt;
        int s;
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                m_busy[i] = 0; m_done[i] = 0; m_note[i] = 0; m_rem[i] = 0; m_phase[i] = 0;
            end
            m_pend = 1'b0;
            m_pend_play = 1'b0;
            exp_q.delete();
        end else begin
            if (m_pend) begin
                s = 0;
                if (m_pend_play)
                    for (int i = 0; i < 3; i++)
                        if (m_busy[i] != 0) s += voice_value(m_phase[i]);
                exp_q.push_back(s);
            end
            m_pend      = generate_next_sample;
            m_pend_play = play;

            tgt = -1;
            if (new_note && note != 0 && duration != 0) begin
                for (int i = 2; i >= 0; i--)
                    if (m_busy[i] == 0) tgt = i;
`ifdef CHORDS_PLAYER_VOICE_STEAL_EN
                if (tgt < 0) begin
                    tgt = 0;
                    for (int i = 1; i < 3; i++)
                        if (m_rem[i] < m_rem[tgt]) tgt = i;
                end
`endif
            end

            for (int i = 0; i < 3; i++) begin
                if (i == tgt) begin
                    m_busy[i] = 1; m_done[i] = 0; m_note[i] = int'(note);
                    m_rem[i] = int'(duration); m_phase[i] = 0;
                end else if (new_frame && m_done[i] != 0) begin
                    m_busy[i] = 0; m_done[i] = 0; m_note[i] = 0; m_rem[i] = 0; m_phase[i] = 0;
                end else if (m_busy[i] != 0) begin
                    if (beat && play && m_done[i] == 0) begin
                        m_rem[i] = m_rem[i] - 1;
                        if (m_rem[i] == 0) m_done[i] = 1;
                    end
                    if (generate_next_sample && play)
                        m_phase[i] = (m_phase[i] + step_of(m_note[i])) % 1048576;
                end
            end
        end
    end

    // Monitor: every ready strobe must match the oldest expected sample, and
    // every expected sample must appear as a strobe.
    always @(negedge clk) begin : monitor
        int e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output("ready_pulse", int'(new_sample_ready), 1);
            check_output("sample_out", int'(sample_out), e);
        end else if (new_sample_ready) begin
            check_output("spurious_ready", int'(new_sample_ready), 0);
        end
    end

    // One clock of stimulus; strobes last exactly this cycle.
    task automatic apply_stimulus(input logic nf, input logic nn, input logic [5:0] nt,
                                  input logic [5:0] du, input logic bt, input logic gen);
        @(negedge clk);
        new_frame            = nf;
        new_note             = nn;
        note                 = nt;
        duration             = du;
        beat                 = bt;
        generate_next_sample = gen;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
    endtask

    task automatic do_note(input logic [5:0] nt, input logic [5:0] du);
        apply_stimulus(1'b0, 1'b1, nt, du, 1'b0, 1'b0);
    endtask

    task automatic do_sample();
        apply_stimulus(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1);
        idle(2);
    endtask

    task automatic do_beat();
        apply_stimulus(1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
    endtask

    task automatic do_frame();
        apply_stimulus(1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b0; new_frame = 1'b0; play = 1'b1; note = 6'd0; duration = 6'd0;
        new_note = 1'b0; beat = 1'b0; generate_next_sample = 1'b0;

        repeat (3) @(negedge clk);
        check_output("reset_sample", int'(sample_out), 0);
        check_output("reset_ready", int'(new_sample_ready), 0);
        reset = 1'b1;

        // Silence with no voices
        do_sample();

        // Single A4, one request, then expire it and release on a frame
        do_note(6'd37, 6'd4);
        do_sample();
        do_sample();
        repeat (4) do_beat();
        do_sample();
        do_frame();
        do_sample();

        // Three-note chord in consecutive strobes
        do_note(6'd37, 6'd5);
        do_note(6'd41, 6'd3);
        do_note(6'd44, 6'd6);
        repeat (3) do_sample();

        // Fourth note while all voices are busy: dropped or steals a voice
        do_beat();
        do_note(6'd50, 6'd2);
        repeat (2) do_sample();

        // Pause: beats ignored, requests answered with silence
        play = 1'b0;
        repeat (3) do_beat();
        do_sample();
        apply_stimulus(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1);
        do_frame();
        play = 1'b1;
        do_sample();

        // Run the chord out; finishing on a frame edge delays release by a frame
        repeat (2) do_beat();
        apply_stimulus(1'b1, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
        do_sample();
        repeat (6) do_beat();
        do_frame();
        do_sample();
        do_frame();
        do_sample();

        // Back-to-back requests
        do_note(6'd61, 6'd2);
        repeat (5) apply_stimulus(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1);
        idle(2);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            new_note             = ($urandom_range(0, 5) == 0);
            note                 = 6'($urandom_range(0, 63));
            duration             = 6'($urandom_range(0, 5));
            beat                 = ($urandom_range(0, 3) == 0);
            new_frame            = ($urandom_range(0, 7) == 0);
            generate_next_sample = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 39) == 0) play = ~play;
        end
        play = 1'b1;
        idle(3);

        // Reset while a request is in flight: no ready pulse may follow
        do_note(6'd30, 6'd9);
        apply_stimulus(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        generate_next_sample = 1'b0;
        #1;
        check_output("midreset_ready", int'(new_sample_ready), 0);
        check_output("midreset_sample", int'(sample_out), 0);
        repeat (2) @(negedge clk);
        check_output("midreset_no_pulse", int'(new_sample_ready), 0);

        // First strobe after release is honoured
        reset = 1'b1;
        new_note = 1'b1; note = 6'd25; duration = 6'd3;
        apply_stimulus(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1);
        idle(2);
        do_sample();
        idle(3);

        check_output("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/chords_player.md
CHORDS_PLAYER -- requirements
Module: chords_player

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-003 SHALL have port new_frame, input, 1, one-cycle frame-boundary strobe.
REQ-004 SHALL have port play, input, 1, 1 = run, 0 = pause.
REQ-005 SHALL have port note, input, 6, note code: 1 = A1 (55 Hz), semitone steps, 37 = A4 (440 Hz); 0 = rest.
REQ-006 SHALL have port duration, input, 6, note length in beats.
REQ-007 SHALL have port new_note, input, 1, one-cycle strobe qualifying note/duration.
REQ-008 SHALL have port beat, input, 1, one-cycle beat strobe.
REQ-009 SHALL have port generate_next_sample, input, 1, one-cycle sample request (48 kHz rate).
REQ-010 SHALL have port sample_out, output, 16, signed two's-complement mixed sample.
REQ-011 SHALL have port new_sample_ready, output, 1, one-cycle strobe: sample_out valid.

Function
REQ-012 SHALL contain 3 voices (0..2), each with: busy flag, 6-bit note, 6-bit remaining beats, done flag, 20-bit phase accumulator.
REQ-013 On new_note with note!=0 and duration!=0, SHALL load the lowest-index non-busy voice: busy=1, done=0, remaining=duration, phase=0.
REQ-014 new_note with note=0 or duration=0 SHALL be ignored.
REQ-015 Multiple strobes SHALL be independent; back-to-back strobes in consecutive cycles SHALL fill consecutive free voices.
REQ-016 new_note with all voices busy SHALL follow REQ-031/REQ-032.
REQ-017 On beat with play=1, each busy voice with done=0 SHALL decrement remaining; on reaching 0 it SHALL set done=1.
REQ-018 A voice loaded in the same cycle as beat SHALL NOT decrement that cycle.
REQ-019 A done voice SHALL keep sounding; on the next new_frame it SHALL clear busy and done.
REQ-020 If done is set in the same cycle as new_frame, the voice SHALL free at the following new_frame.
REQ-021 Phase step SHALL be a 63-entry constant table: step(n) = round(2^20 * 55 * 2^((n-1)/12) / 48000), e.g. step(1)=1201, step(37)=9612.
REQ-022 On generate_next_sample with play=1, each busy voice SHALL add step(note) to its phase, modulo 2^20; idle voices SHALL hold phase 0.
REQ-023 Voice waveform SHALL be a triangle: tri = phase[19] ? ~phase[18:6] : phase[18:6] (13 bits); voice value = {tri,0} - 8192 (14-bit signed); idle voice contributes 0.
REQ-024 Mix SHALL be the signed sum of the 3 voice values, sign-extended to 16 bits; no saturation is needed (range -24576..24570).
REQ-025 Latency: generate_next_sample at edge N advances phases; at edge N+1 sample_out is registered with the mix and new_sample_ready=1 for exactly that one cycle.
REQ-026 With play=0: phases and beat countdown SHALL freeze; note loading and new_frame release SHALL still operate; requests SHALL still get new_sample_ready, with sample_out=0.
REQ-027 generate_next_sample arriving while the previous one is still in flight SHALL be serviced in order; each request yields exactly one ready pulse.

Reset
REQ-028 While reset=0, asynchronously: all voices idle (busy=0, done=0, note=0, remaining=0, phase=0), sample_out=0, new_sample_ready=0.
REQ-029 Reset asserted mid-note SHALL discard all voices immediately; no ready pulse SHALL be issued for an in-flight request.
REQ-030 The first strobe honoured SHALL be the one sampled at the first rising edge after reset=1.

Configuration
REQ-031 With macro CHORDS_PLAYER_VOICE_STEAL_EN defined, new_note with all voices busy SHALL replace the voice with the smallest remaining count (lowest index on tie), reloaded per REQ-013.
REQ-032 Without CHORDS_PLAYER_VOICE_STEAL_EN, new_note with all voices busy SHALL be dropped with no state change.

Verification
REQ-033 Reset low, then high; pulse generate_next_sample -> new_sample_ready exactly 1 cycle later, sample_out=0.
REQ-034 new_note note=37 duration=4; 1 sample request -> voice0 phase=9612, sample_out=0x0000+(({9612>>6,0})-8192)=-7892.
REQ-035 Same note; 4 beats then new_frame -> voice0 idle; next sample_out=0.
REQ-036 Notes 37, 41, 44 in consecutive strobes -> voices 0, 1, 2 busy; sample_out equals the sum of three triangle values.
REQ-037 Four notes with 3 busy -> 4th dropped without macro; with macro, it replaces the min-remaining voice.
REQ-038 play=0 during a chord -> remaining counts unchanged across beats; sample_out=0 with ready pulses continuing.
